// File: rtl/exec_sequencer.sv
// exec_sequencer: four-state (IDLE/DECODE/EXEC/WRITE) sequencer for RV32 R-type
// ALU instructions. Accepts one instruction per handshake, decodes register
// indices and the ALU select, holds them through one execute cycle, then issues
// a one-cycle register-file write strobe and retire pulse.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   instr_valid/instr   instruction offer (RV32 word)
//   instr_ready         high only in IDLE while reset is low
//   rs1, rs2, rd        register indices to the execute stage
//   alu_control         ALU operation select
//   write_en            register file write strobe (WRITE, rd != 0)
//   zero_flag/zero_out  ALU zero flag in, captured value of last retire out
//   done, illegal       one-cycle retire / illegal-instruction pulses
//   retired_count       wrapping retired-instruction counter
module exec_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [3:0]       alu_control,
  output logic             write_en,
  input  logic             zero_flag,
  output logic             zero_out,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WRITE} state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t             state, state_nxt;
  logic [31:0]        instr_q, instr_q_nxt;
  logic [4:0]         rs1_nxt, rs2_nxt, rd_nxt;
  logic [3:0]         alu_control_nxt;
  logic               write_en_nxt, zero_out_nxt, done_nxt, illegal_nxt;
  logic [CNT_W-1:0]   retired_count_nxt;

  logic [6:0]         opcode_c, funct7_c;
  logic [2:0]         funct3_c;
  logic               legal_c;
  logic [3:0]         alu_dec_c;

  assign opcode_c = instr_q[6:0];
  assign funct3_c = instr_q[14:12];
  assign funct7_c = instr_q[31:25];

  // Combinational decode of the latched instruction word
  always_comb begin
    legal_c   = 1'b0;
    alu_dec_c = ALU_ADD;
    if (opcode_c == OP_RTYPE) begin
      if (funct7_c == F7_BASE)
        legal_c = 1'b1;
      else if (funct7_c == F7_ALT && (funct3_c == 3'b000 || funct3_c == 3'b101))
        legal_c = 1'b1;
    end
    unique case (funct3_c)
      3'b000:  alu_dec_c = funct7_c[5] ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec_c = ALU_SLL;
      3'b010:  alu_dec_c = ALU_SLT;
      3'b011:  alu_dec_c = ALU_SLTU;
      3'b100:  alu_dec_c = ALU_XOR;
      3'b101:  alu_dec_c = funct7_c[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec_c = ALU_OR;
      default: alu_dec_c = ALU_AND;
    endcase
  end

  // Ready is combinational so it drops in the same cycle reset rises
  assign instr_ready = (state == IDLE) && !reset;

  // Next-state and next-output logic
  always_comb begin
    state_nxt         = state;
    instr_q_nxt       = instr_q;
    rs1_nxt           = rs1;
    rs2_nxt           = rs2;
    rd_nxt            = rd;
    alu_control_nxt   = alu_control;
    zero_out_nxt      = zero_out;
    retired_count_nxt = retired_count;
    write_en_nxt      = 1'b0;
    done_nxt          = 1'b0;
    illegal_nxt       = 1'b0;

    unique case (state)
      IDLE: begin
        if (instr_valid) begin
          instr_q_nxt = instr;
          state_nxt   = DECODE;
        end
      end
      DECODE: begin
        rs1_nxt         = instr_q[19:15];
        rs2_nxt         = instr_q[24:20];
        rd_nxt          = instr_q[11:7];
        alu_control_nxt = alu_dec_c;
        if (legal_c) begin
          state_nxt = EXEC;
        end else begin
          illegal_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      EXEC: begin
        zero_out_nxt = zero_flag;
        write_en_nxt = (rd != 5'd0);
        done_nxt     = 1'b1;
        state_nxt    = WRITE;
      end
      default: begin
        retired_count_nxt = retired_count + CNT_W'(1);
        state_nxt         = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      instr_q       <= 32'd0;
      rs1           <= 5'd0;
      rs2           <= 5'd0;
      rd            <= 5'd0;
      alu_control   <= 4'd0;
      write_en      <= 1'b0;
      zero_out      <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_nxt;
      instr_q       <= instr_q_nxt;
      rs1           <= rs1_nxt;
      rs2           <= rs2_nxt;
      rd            <= rd_nxt;
      alu_control   <= alu_control_nxt;
      write_en      <= write_en_nxt;
      zero_out      <= zero_out_nxt;
      done          <= done_nxt;
      illegal       <= illegal_nxt;
      retired_count <= retired_count_nxt;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer. A default-width instance and
// a CNT_W=4 instance share the same stimulus so counter wrap can be observed.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        zero_flag;

  logic        instr_ready, write_en, zero_out, done, illegal;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_control;
  logic [15:0] retired_count;

  logic        instr_ready4, write_en4, zero_out4, done4, illegal4;
  logic [4:0]  rs1_4, rs2_4, rd_4;
  logic [3:0]  alu_control4;
  logic [3:0]  retired_count4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_cnt  = 0;
  logic        exp_zo   = 1'b0;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_control(alu_control), .write_en(write_en), .zero_flag(zero_flag),
    .zero_out(zero_out), .done(done), .illegal(illegal),
    .retired_count(retired_count)
  );

  exec_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready4), .rs1(rs1_4), .rs2(rs2_4), .rd(rd_4),
    .alu_control(alu_control4), .write_en(write_en4), .zero_flag(zero_flag),
    .zero_out(zero_out4), .done(done4), .illegal(illegal4),
    .retired_count(retired_count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; return at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt"},  32'(retired_count),  exp_cnt & 32'hFFFF);
    check({tag, "_cnt4"}, 32'(retired_count4), exp_cnt & 32'hF);
  endtask

  // Offer one instruction from IDLE and check each stage of its progress
  task automatic exec_instr(input logic [31:0] w, input logic zf,
                            input logic legal, input logic [3:0] e_alu);
    int unsigned waited;
    logic [4:0] e_rd;
    e_rd   = w[11:7];
    waited = 0;
    while (!instr_ready && waited < 8) begin
      step();
      waited++;
    end
    if (!instr_ready) check("ready_timeout", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr       = w;
    zero_flag   = zf;
    step();
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
    // DECODE
    check("dec_ready", 32'(instr_ready), 32'd0);
    check("dec_we",    32'(write_en),    32'd0);
    check("dec_done",  32'(done),        32'd0);
    step();
    if (legal) begin
      // EXEC
      check("ex_rs1", 32'(rs1), 32'(w[19:15]));
      check("ex_rs2", 32'(rs2), 32'(w[24:20]));
      check("ex_rd",  32'(rd),  32'(e_rd));
      check("ex_alu", 32'(alu_control), 32'(e_alu));
      check("ex_we",  32'(write_en), 32'd0);
      check("ex_ill", 32'(illegal),  32'd0);
      step();
      // WRITE
      check("wr_we",   32'(write_en), (e_rd != 5'd0) ? 32'd1 : 32'd0);
      check("wr_done", 32'(done),     32'd1);
      check("wr_ill",  32'(illegal),  32'd0);
      check("wr_zo",   32'(zero_out), 32'(zf));
      check("wr_ready", 32'(instr_ready), 32'd0);
      exp_cnt++;
      exp_zo = zf;
      step();
      // Back in IDLE
      check("id_we",    32'(write_en), 32'd0);
      check("id_done",  32'(done),     32'd0);
      check("id_ready", 32'(instr_ready), 32'd1);
      check("id_alu",   32'(alu_control), 32'(e_alu));
      check_counts("id");
    end else begin
      check("il_pulse", 32'(illegal),  32'd1);
      check("il_done",  32'(done),     32'd0);
      check("il_we",    32'(write_en), 32'd0);
      check("il_ready", 32'(instr_ready), 32'd1);
      check("il_zo",    32'(zero_out), 32'(exp_zo));
      step();
      check("il_clear", 32'(illegal),  32'd0);
      check("il_we2",   32'(write_en), 32'd0);
      check("il_zo2",   32'(zero_out), 32'(exp_zo));
      check_counts("il");
    end
  endtask

  logic [31:0] b2b [3];
  logic [4:0]  seen_rd [$];
  int unsigned ready_cycles;
  int unsigned k;

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr       = 32'h0020_81B3;
    zero_flag   = 1'b0;
    step();
    step();
    // Reset state, with a valid offer that must not be taken
    check("rst_ready", 32'(instr_ready), 32'd0);
    check("rst_rs1",   32'(rs1), 32'd0);
    check("rst_rd",    32'(rd),  32'd0);
    check("rst_we",    32'(write_en), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ill",   32'(illegal), 32'd0);
    check("rst_zo",    32'(zero_out), 32'd0);
    check_counts("rst");
    instr_valid = 1'b0;
    reset       = 1'b0;
    #1;
    check("post_rst_ready", 32'(instr_ready), 32'd1);

    // Legal instructions across the encodings
    exec_instr(32'h0020_81B3, 1'b0, 1'b1, 4'b0000);  // add x3,x1,x2
    exec_instr(32'h4020_8133, 1'b1, 1'b1, 4'b0001);  // sub x2,x1,x2, zero
    exec_instr(32'h0020_8033, 1'b0, 1'b1, 4'b0000);  // add x0 -> no write
    exec_instr(32'h4020_D1B3, 1'b1, 1'b1, 4'b0111);  // sra
    exec_instr(32'h0020_E1B3, 1'b1, 1'b1, 4'b0011);  // or
    exec_instr(32'h0020_B1B3, 1'b1, 1'b1, 4'b1001);  // sltu, leaves zero_out=1

    // Illegal forms: zero_flag low must not disturb zero_out
    exec_instr(32'h4020_9133, 1'b0, 1'b0, 4'b0000);  // funct7 0100000, funct3 001
    exec_instr(32'h0000_0013, 1'b0, 1'b0, 4'b0000);  // addi
    exec_instr(32'h0220_81B3, 1'b0, 1'b0, 4'b0000);  // mul (funct7 0000001)

    // Back-to-back with valid held high
    b2b[0] = 32'h0020_82B3;  // add x5
    b2b[1] = 32'h0020_C333;  // xor x6
    b2b[2] = 32'h0020_93B3;  // sll x7
    ready_cycles = 0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_ready) begin
        ready_cycles++;
        if (k < 3) begin
          instr_valid = 1'b1;
          instr       = b2b[k];
          k++;
        end
      end
      if (done) seen_rd.push_back(rd);
      step();
    end
    instr_valid = 1'b0;
    if (done) seen_rd.push_back(rd);
    exp_cnt += 3;
    check("b2b_ready_cycles", ready_cycles, 32'd3);
    check("b2b_retires", 32'(seen_rd.size()), 32'd3);
    if (seen_rd.size() == 3) begin
      check("b2b_rd0", 32'(seen_rd[0]), 32'd5);
      check("b2b_rd1", 32'(seen_rd[1]), 32'd6);
      check("b2b_rd2", 32'(seen_rd[2]), 32'd7);
    end
    step();
    check_counts("b2b");

    // Reset while in EXEC abandons the instruction
    instr_valid = 1'b1;
    instr       = 32'h0020_81B3;
    step();
    instr_valid = 1'b0;
    step();                       // now in EXEC
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(instr_ready), 32'd0);
    step();
    reset = 1'b0;
    exp_cnt = 0;
    exp_zo  = 1'b0;
    check("mid_rst_we",   32'(write_en), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_zo",   32'(zero_out), 32'd0);
    check_counts("mid_rst");
    step();
    check("mid_rst_we2", 32'(write_en), 32'd0);
    check("mid_rst_done2", 32'(done), 32'd0);

    // 17 retires: the 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++)
      exec_instr((i % 2 == 0) ? 32'h0020_8033 : 32'h0020_80B3, 1'b0, 1'b1, 4'b0000);
    check("wrap_cnt4", 32'(retired_count4), 32'd1);
    check("wrap_cnt",  32'(retired_count),  32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
